// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one-cycle pipeline register with valid/ready handshake, HOLD stall and FLUSH kill.
// Latency 1; define PIPE_SKID_EN to add a skid entry so IN_READY has no path from OUT_READY.
// Backpressure: without skid, IN_READY follows OUT_READY when the main entry is held.
module pipe_stage_reg #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              HOLD,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [CTRL_W-1:0] IN_CTRL,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [CTRL_W-1:0] OUT_CTRL,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [1:0]        OCCUPANCY
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_nxt;
  logic [DATA_W-1:0] main_data, main_data_nxt;
  logic              out_valid;
  logic              in_ready;
  logic              accept;
  logic              drain;

`ifdef PIPE_SKID_EN
  logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_nxt;
  logic [DATA_W-1:0] skid_data, skid_data_nxt;

  assign out_valid = (state == BUSY) | (state == FULL);
  assign in_ready  = (state != FULL) & ~HOLD;
`else
  assign out_valid = (state == BUSY);
  assign in_ready  = ~HOLD & (~out_valid | OUT_READY);
`endif

  assign accept = IN_VALID & in_ready;
  assign drain  = out_valid & OUT_READY & ~HOLD;

  always_comb begin
    state_nxt     = state;
    main_ctrl_nxt = main_ctrl;
    main_data_nxt = main_data;
`ifdef PIPE_SKID_EN
    skid_ctrl_nxt = skid_ctrl;
    skid_data_nxt = skid_data;
`endif
    if (FLUSH) begin
      state_nxt     = EMPTY;
      main_ctrl_nxt = '0;
      main_data_nxt = '0;
`ifdef PIPE_SKID_EN
      skid_ctrl_nxt = '0;
      skid_data_nxt = '0;
`endif
    end else if (!HOLD) begin
      case (state)
        BUSY: begin
          if (accept) begin
`ifdef PIPE_SKID_EN
            if (drain) begin
              main_ctrl_nxt = IN_CTRL;
              main_data_nxt = IN_DATA;
            end else begin
              skid_ctrl_nxt = IN_CTRL;
              skid_data_nxt = IN_DATA;
              state_nxt     = FULL;
            end
`else
            // accept in BUSY implies a simultaneous drain when there is no skid
            main_ctrl_nxt = IN_CTRL;
            main_data_nxt = IN_DATA;
`endif
          end else if (drain) begin
            state_nxt = EMPTY;
          end
        end
`ifdef PIPE_SKID_EN
        FULL: begin
          if (drain) begin
            main_ctrl_nxt = skid_ctrl;
            main_data_nxt = skid_data;
            state_nxt     = BUSY;
          end
        end
`endif
        default: begin
          // EMPTY and any unreachable encoding
          if (accept) begin
            main_ctrl_nxt = IN_CTRL;
            main_data_nxt = IN_DATA;
            state_nxt     = BUSY;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
`ifdef PIPE_SKID_EN
      skid_ctrl <= '0;
      skid_data <= '0;
`endif
    end else begin
      state     <= state_nxt;
      main_ctrl <= main_ctrl_nxt;
      main_data <= main_data_nxt;
`ifdef PIPE_SKID_EN
      skid_ctrl <= skid_ctrl_nxt;
      skid_data <= skid_data_nxt;
`endif
    end
  end

  always_comb begin
    OCCUPANCY = 2'd0;
    case (state)
      BUSY:    OCCUPANCY = 2'd1;
`ifdef PIPE_SKID_EN
      FULL:    OCCUPANCY = 2'd2;
`endif
      default: OCCUPANCY = 2'd0;
    endcase
  end

  assign IN_READY  = in_ready;
  assign OUT_VALID = out_valid;
  assign OUT_CTRL  = out_valid ? main_ctrl : '0;
  assign OUT_DATA  = main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a queue model of held entries; works with or without PIPE_SKID_EN.
module tb_pipe_stage_reg;
  localparam int CW = 16;
  localparam int DW = 128;

  logic          CLK = 1'b0;
  logic          RESET, FLUSH, HOLD, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [CW-1:0] IN_CTRL, OUT_CTRL;
  logic [DW-1:0] IN_DATA, OUT_DATA;
  logic [1:0]    OCCUPANCY;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .HOLD(HOLD),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_CTRL(IN_CTRL), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_CTRL(OUT_CTRL), .OUT_DATA(OUT_DATA),
    .OCCUPANCY(OCCUPANCY)
  );

  function automatic logic exp_ready();
`ifdef PIPE_SKID_EN
    return !HOLD && (q.size() < 2);
`else
    return !HOLD && ((q.size() == 0) || OUT_READY);
`endif
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("occupancy", DW'(OCCUPANCY), DW'(q.size()));
    chk("out_valid", DW'(OUT_VALID), DW'(q.size() != 0));
    chk("in_ready", DW'(IN_READY), DW'(exp_ready()));
    if (q.size() == 0) begin
      chk("out_ctrl_bubble", DW'(OUT_CTRL), '0);
    end else begin
      chk("out_ctrl", DW'(OUT_CTRL), DW'(q[0].c));
      chk("out_data", OUT_DATA, q[0].d);
    end
  endtask

  // Checks mid-cycle, then advances the model across the next rising edge.
  task automatic tick();
    logic acc;
    logic drn;
    @(negedge CLK);
    check_state();
    acc = IN_VALID && exp_ready();
    drn = (q.size() != 0) && OUT_READY && !HOLD;
    if (RESET || FLUSH) begin
      q.delete();
    end else if (!HOLD) begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back('{c: IN_CTRL, d: IN_DATA});
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d, input logic ordy);
    IN_VALID  = v;
    IN_CTRL   = c;
    IN_DATA   = d;
    OUT_READY = ordy;
  endtask

  initial begin
    RESET = 1'b1; FLUSH = 1'b0; HOLD = 1'b0;
    drive(1'b0, '0, '0, 1'b0);

    // reset state, before any clock edge
    #3;
    chk("rst_out_valid", DW'(OUT_VALID), '0);
    chk("rst_out_data", OUT_DATA, '0);
    chk("rst_occupancy", DW'(OCCUPANCY), '0);
    chk("rst_in_ready", DW'(IN_READY), DW'(1));
    tick();
    tick();
    RESET = 1'b0;

    // streaming 1..4, accepted from the first edge after reset release
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, CW'(i), DW'(i), 1'b1);
      tick();
    end
    drive(1'b0, '0, '0, 1'b1);
    tick();
    tick();

    // backpressure
    drive(1'b1, 16'h0011, 128'hAA, 1'b0);
    tick();
    drive(1'b1, 16'h0022, 128'hBB, 1'b0);
`ifdef PIPE_SKID_EN
    tick();
    drive(1'b0, '0, '0, 1'b0);
    #1;
    chk("bp_occ_full", DW'(OCCUPANCY), DW'(2));
    chk("bp_rdy_full", DW'(IN_READY), '0);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    tick();
    chk("bp_rdy_after_drain", DW'(IN_READY), DW'(1));
    tick();
    tick();
`else
    #1;
    chk("ns_rdy_low", DW'(IN_READY), '0);
    tick();
    tick();
    chk("ns_occ_max", DW'(OCCUPANCY), DW'(1));
    drive(1'b1, 16'h0022, 128'hBB, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    tick();
    tick();
`endif

    // HOLD keeps the head entry and blocks input
    drive(1'b1, 16'h00A5, 128'h55, 1'b0);
    tick();
    drive(1'b1, 16'h0007, 128'h66, 1'b1);
    HOLD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_ctrl", DW'(OUT_CTRL), DW'(16'h00A5));
      chk("hold_rdy", DW'(IN_READY), '0);
    end
    HOLD = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    tick();
    chk("hold_drained", DW'(OUT_VALID), '0);
    tick();

    // FLUSH over HOLD with the stage filled
    drive(1'b1, 16'h0031, 128'hC1, 1'b0);
    tick();
`ifdef PIPE_SKID_EN
    drive(1'b1, 16'h0032, 128'hC2, 1'b0);
    tick();
`endif
    drive(1'b1, 16'h0099, 128'hDEAD, 1'b1);
    HOLD = 1'b1; FLUSH = 1'b1;
    tick();
    HOLD = 1'b0; FLUSH = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    chk("flush_valid", DW'(OUT_VALID), '0);
    chk("flush_ctrl", DW'(OUT_CTRL), '0);
    chk("flush_data", OUT_DATA, '0);
    chk("flush_occ", DW'(OCCUPANCY), '0);
    tick();
    tick();

    // async reset mid-cycle while BUSY
    drive(1'b1, 16'h0044, 128'hD4, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    #2;
    RESET = 1'b1;
    #1;
    chk("arst_valid", DW'(OUT_VALID), '0);
    chk("arst_data", OUT_DATA, '0);
    chk("arst_occ", DW'(OCCUPANCY), '0);
    chk("arst_rdy", DW'(IN_READY), DW'(1));
    q.delete();
    tick();
    RESET = 1'b0;
    drive(1'b1, 16'h0045, 128'hE5, 1'b1);
    tick();
    chk("post_rst_accept", DW'(OUT_VALID), DW'(1));
    drive(1'b0, '0, '0, 1'b1);
    tick();

    // random mix of valid, ready and stalls
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), CW'(16'h100 + i), DW'(1000 + i), 1'($urandom_range(0, 1)));
      HOLD = ($urandom_range(0, 7) == 0);
      tick();
    end
    HOLD = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    tick();
    tick();
    tick();
    chk("final_empty", DW'(OCCUPANCY), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
